mr_booth_multiplier: RTL and testbench



---
 rtl/mr_booth_multiplier.sv | 178 +++++++++++++++++
 tb/tb_mr_booth_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mr_booth_multiplier.sv
// -----------------------------------------------------------------------------
// mr_booth_multiplier
//
// Multi-cycle signed radix-2 Booth multiplier. One Booth iteration per clock.
// The 32-bit product is returned as a high half (mr_out, feeds the
// seven-segment display stage's MR input) and a low half (acc_out).
//
// Handshake: start is sampled only in IDLE. busy is high outside IDLE. done
// is a registered one-cycle pulse. Results hold until the next completion.
// With start accepted at edge E0, iterations run at E1..E16. done is high
// after E16. The block is back in IDLE after E17.
//
// Ports
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a multiply (ignored unless IDLE)
//   a_in     in   WIDTH  multiplicand (ACC), two's complement
//   b_in     in   WIDTH  multiplier (MBR), two's complement
//   busy     out  high whenever state != IDLE
//   done     out  one-cycle pulse, results valid
//   acc_out  out  WIDTH  product[WIDTH-1:0]
//   mr_out   out  WIDTH  product[2*WIDTH-1:WIDTH]
//   ovf      out  only when MUL_OVF_FLAG_EN is defined. It is set when the
//                 product does not fit in WIDTH signed bits.
//
// Configuration
//   MUL_OVF_FLAG_EN  adds the registered ovf output.
//
// Only WIDTH = 16 is supported.
// -----------------------------------------------------------------------------
module mr_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // A and M carry one extra sign bit, so A +/- M cannot overflow.
  // This holds even for M = -2^(WIDTH-1).
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   addsub;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             last_iter;

  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (state == S_RUN) && (count == LAST_ITER);
  assign busy      = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assigning a default first means no path leaves state_next
  // unassigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start)     state_next = S_RUN;
      S_RUN:  if (last_iter) state_next = S_DONE;
      S_DONE:                state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One Booth step. The recoding pair {Q[0], Q-1} selects A-M, A+M or A.
  // Then {A,Q,Q-1} is shifted right arithmetically, replicating A's sign.
  // ---------------------------------------------------------------------------
  always_comb begin
    addsub = a_reg;
    case ({q_reg[0], q_m1})
      2'b10:   addsub = a_reg - m_reg;
      2'b01:   addsub = a_reg + m_reg;
      default: addsub = a_reg;
    endcase
    a_next = {addsub[WIDTH], addsub[WIDTH:1]};
    q_next = {addsub[0], q_reg[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      m_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      // Operands are captured only here. Later changes on a_in/b_in do not
      // disturb the operation in flight.
      a_reg <= '0;
      m_reg <= {a_in[WIDTH-1], a_in};
      q_reg <= b_in;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == S_RUN) begin
      a_reg <= a_next;
      q_reg <= q_next;
      q_m1  <= q_reg[0];
      count <= count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers. They update only on the final iteration and otherwise
  // hold the last completed product. The post-shift values are the product.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      acc_out <= '0;
      mr_out  <= '0;
    end else begin
      done <= last_iter;
      if (last_iter) begin
        acc_out <= q_next;
        mr_out  <= a_next[WIDTH-1:0];
      end
    end
  end

`ifdef MUL_OVF_FLAG_EN
  // The product fits in WIDTH signed bits only when the high half is a pure
  // sign extension of the low half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (last_iter) begin
      ovf <= (a_next[WIDTH-1:0] != {WIDTH{q_next[WIDTH-1]}});
    end
  end
`endif

endmodule

// File: tb/tb_mr_booth_multiplier.sv
// -----------------------------------------------------------------------------
// tb_mr_booth_multiplier
//
// Self-checking bench for mr_booth_multiplier. The reference model is plain
// signed integer multiplication. The bench covers:
//   - directed corner cases
//   - the ignored-start / operand-capture scenario
//   - reset in the middle of a run
//   - randomized operands
// -----------------------------------------------------------------------------
module tb_mr_booth_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] acc_out;
  logic [15:0] mr_out;
`ifdef MUL_OVF_FLAG_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  mr_booth_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .acc_out (acc_out),
    .mr_out  (mr_out)
`ifdef MUL_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference model: exact signed product of two 16-bit operands.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p;
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return (p > 32767) || (p < -32768);
  endfunction

  // Counts edges from the call point until done is seen (sampled 1 time unit
  // after each edge). Gives up after 40 edges and returns -1.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = ref_prod(a, b);
    check({tag, "_acc"}, acc_out, p[15:0]);
    check({tag, "_mr"},  mr_out,  p[31:16]);
`ifdef MUL_OVF_FLAG_EN
    check({tag, "_ovf"}, ovf, ref_ovf(a, b));
`endif
  endtask

  // Presents operands with start. The accepting edge is E0. Afterwards the
  // operand bus is scrambled to prove that the operands were captured.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    issue(a, b);
    wait_done(n);
    check({tag, "_latency"}, n, 16);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_acc",  acc_out, 16'h0000);
    check("rst_mr",   mr_out,  16'h0000);
`ifdef MUL_OVF_FLAG_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including the sign and corner cases.
    run_mul("m3x5",       16'h0003, 16'h0005);
    check("m3x5_acc_const", acc_out, 16'h000F);
    run_mul("neg1x1",     16'hFFFF, 16'h0001);
    check("neg1x1_mr_const", mr_out, 16'hFFFF);
    run_mul("maxpos",     16'h7FFF, 16'h7FFF);
    check("maxpos_mr_const", mr_out, 16'h3FFF);
    run_mul("minneg",     16'h8000, 16'h8000);
    check("minneg_mr_const", mr_out, 16'h4000);
    run_mul("min_x_max",  16'h8000, 16'h7FFF);
    run_mul("zero_x_min", 16'h0000, 16'h8000);
    run_mul("neg_x_neg",  16'hFFFF, 16'hFFFF);

    // A start during RUN/DONE is ignored. The operands are already captured.
    issue(16'h0002, 16'h0003);
    repeat (4) @(posedge clk);
    #1;
    a_in  = 16'h0007;
    b_in  = 16'h0007;
    start = 1'b1;                    // Asserted for E5 onward.
    wait_done(n);
    check("ign_latency", n, 12);     // Counted from E5, so done after E16.
    check("ign_acc", acc_out, 16'h0006);
    check("ign_mr",  mr_out,  16'h0000);
    @(posedge clk);                  // E17: start still high, but in DONE.
    #1;
    check("ign_busy_e17", busy, 1'b0);
    check("ign_done_e17", done, 1'b0);
    @(posedge clk);                  // E18: first IDLE edge, accepts 7x7.
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(n);
    check("b2b_latency", n, 16);
    check("b2b_acc", acc_out, 16'h0031);
    check_result("b2b", 16'h0007, 16'h0007);
    @(posedge clk);
    #1;
    check("b2b_busy_fall", busy, 1'b0);

    // Reset in the middle of a run.
    issue(16'h1234, 16'h0567);
    repeat (8) @(posedge clk);       // E8
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc",  acc_out, 16'h0000);
    check("mid_rst_mr",   mr_out,  16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
`ifdef MUL_OVF_FLAG_EN
    check("mid_rst_ovf", ovf, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_done", {busy, done}, 2'b00);
    end
    run_mul("after_rst", 16'h0004, 16'h0004);
    check("after_rst_acc_const", acc_out, 16'h0010);

    // Randomized operands against the model.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 1) ra = 16'($urandom_range(0, 15)) - 16'd8;
      if (i % 4 == 2) rb = 16'($urandom_range(0, 15)) - 16'd8;
      run_mul("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
